// File: rtl/pong_ctrl.sv
// One-row pong game controller: ball position/direction, step timing,
// paddle hit windows, scoring and serve/rally/point/game-over sequencing.
module pong_ctrl #(
  parameter int DIV       = 24,
  parameter int PAUSE     = 8,
  parameter int WIN_SCORE = 9
) (
  input  logic       CLK,
  input  logic       AR,
  input  logic       SERVE,
  input  logic       BTN_L,
  input  logic       BTN_R,
  output logic [2:0] POS,
  output logic       DIR,
  output logic [3:0] SCORE_L,
  output logic [3:0] SCORE_R,
  output logic       FLASH,
  output logic       OVER,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SERVE_WAIT = 3'd1,
    MOVE       = 3'd2,
    POINT      = 3'd3,
    GAME_OVER  = 3'd4
  } state_t;

  localparam int              CNT_W    = (DIV > 0) ? $clog2(DIV + 1) : 1;
  localparam int              PSE_W    = (PAUSE > 1) ? $clog2(PAUSE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV);
  localparam logic [PSE_W-1:0] PSE_LAST = PSE_W'((PAUSE > 0) ? PAUSE - 1 : 0);
  localparam logic [3:0]      WIN      = 4'(WIN_SCORE);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [PSE_W-1:0] pse_cnt;
  logic             serve_q, btn_l_q, btn_r_q;
  logic             hit_l_q, hit_r_q;

  logic serve_edge, edge_l, edge_r;
  logic run, tick;
  logic win_l, win_r;
  logic hit_l, hit_r;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

  assign serve_edge = SERVE & ~serve_q;
  assign edge_l     = BTN_L & ~btn_l_q;
  assign edge_r     = BTN_R & ~btn_r_q;

  assign run  = (state == MOVE) || (state == POINT);
  assign tick = run && (cnt == CNT_MAX);

  assign win_l = (state == MOVE) && (POS == 3'd7) && DIR;
  assign win_r = (state == MOVE) && (POS == 3'd0) && !DIR;

  // A paddle edge landing on the tick cycle still counts as a hit.
  assign hit_l = hit_l_q | (edge_l & win_l);
  assign hit_r = hit_r_q | (edge_r & win_r);

  assign STATE = state;

  always_ff @(posedge CLK or negedge AR) begin
    if (!AR) begin
      state   <= IDLE;
      POS     <= 3'd0;
      DIR     <= 1'b1;
      SCORE_L <= 4'd0;
      SCORE_R <= 4'd0;
      FLASH   <= 1'b0;
      OVER    <= 1'b0;
      cnt     <= '0;
      pse_cnt <= '0;
      hit_l_q <= 1'b0;
      hit_r_q <= 1'b0;
      // History starts high so a button held through reset is not an edge.
      serve_q <= 1'b1;
      btn_l_q <= 1'b1;
      btn_r_q <= 1'b1;
    end else begin
      serve_q <= SERVE;
      btn_l_q <= BTN_L;
      btn_r_q <= BTN_R;

      // Counter idles at 0 outside MOVE/POINT and every transition into
      // those states happens from 0 or on a tick, so entry always sees 0.
      if (run && !tick) cnt <= cnt + 1'b1;
      else              cnt <= '0;

      if ((state != MOVE) || tick) begin
        hit_l_q <= 1'b0;
        hit_r_q <= 1'b0;
      end else begin
        if (edge_l && win_l) hit_l_q <= 1'b1;
        if (edge_r && win_r) hit_r_q <= 1'b1;
      end

      case (state)
        IDLE: state <= SERVE_WAIT;

        SERVE_WAIT: begin
          if (serve_edge) state <= MOVE;
        end

        MOVE: begin
          if (tick) begin
            if (DIR) begin
              if (POS != 3'd7) begin
                POS <= POS + 3'd1;
              end else if (hit_l) begin
                DIR <= 1'b0;
                POS <= 3'd6;
              end else begin
                SCORE_R <= sat_inc(SCORE_R);
                DIR     <= 1'b0;
                FLASH   <= 1'b1;
                pse_cnt <= '0;
                state   <= POINT;
              end
            end else begin
              if (POS != 3'd0) begin
                POS <= POS - 3'd1;
              end else if (hit_r) begin
                DIR <= 1'b1;
                POS <= 3'd1;
              end else begin
                SCORE_L <= sat_inc(SCORE_L);
                DIR     <= 1'b1;
                FLASH   <= 1'b1;
                pse_cnt <= '0;
                state   <= POINT;
              end
            end
          end
        end

        POINT: begin
          if (tick) begin
            if (pse_cnt == PSE_LAST) begin
              FLASH <= 1'b0;
              if ((SCORE_L == WIN) || (SCORE_R == WIN)) begin
                OVER  <= 1'b1;
                state <= GAME_OVER;
              end else begin
                state <= SERVE_WAIT;
              end
            end else begin
              pse_cnt <= pse_cnt + 1'b1;
              FLASH   <= ~FLASH;
            end
          end
        end

        GAME_OVER: begin
          if (serve_edge) begin
            SCORE_L <= 4'd0;
            SCORE_R <= 4'd0;
            POS     <= 3'd0;
            DIR     <= 1'b1;
            OVER    <= 1'b0;
            state   <= SERVE_WAIT;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_ctrl.sv
// Scoreboard bench for pong_ctrl (DIV=1, PAUSE=4, WIN_SCORE=2): stimulus queues
// hand-computed output snapshots per cycle, a negedge monitor pops and compares.
module tb_pong_ctrl;

  logic       CLK = 1'b0;
  logic       AR, SERVE, BTN_L, BTN_R;
  logic [2:0] POS;
  logic       DIR;
  logic [3:0] SCORE_L, SCORE_R;
  logic       FLASH, OVER;
  logic [2:0] STATE;

  pong_ctrl #(.DIV(1), .PAUSE(4), .WIN_SCORE(2)) dut (
    .CLK(CLK), .AR(AR), .SERVE(SERVE), .BTN_L(BTN_L), .BTN_R(BTN_R),
    .POS(POS), .DIR(DIR), .SCORE_L(SCORE_L), .SCORE_R(SCORE_R),
    .FLASH(FLASH), .OVER(OVER), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          at;
    string       nm;
    logic [16:0] v;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Expected snapshot: pos, dir, score_l, score_r, flash, over, state.
  task automatic expect_at(input int at, input string nm, input int pos, input int dir,
                           input int sl, input int sr, input int fl, input int ov,
                           input int st);
    exp_t e;
    e.at = at;
    e.nm = nm;
    e.v  = {3'(pos), 1'(dir), 4'(sl), 4'(sr), 1'(fl), 1'(ov), 3'(st)};
    q.push_back(e);
  endtask

  task automatic go(input int c);
    while (cyc < c) begin
      @(posedge CLK);
      #1;
    end
  endtask

  always @(negedge CLK) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      exp_t        e;
      logic [16:0] a;
      e = q.pop_front();
      a = {POS, DIR, SCORE_L, SCORE_R, FLASH, OVER, STATE};
      checks++;
      if (e.at != cyc || a !== e.v) begin
        errors++;
        $display("FAIL %s cycle %0d (due %0d): got pos=%0d dir=%0d sl=%0d sr=%0d flash=%0d over=%0d state=%0d, expected pos=%0d dir=%0d sl=%0d sr=%0d flash=%0d over=%0d state=%0d",
                 e.nm, cyc, e.at, a[16:14], a[13], a[12:9], a[8:5], a[4], a[3], a[2:0],
                 e.v[16:14], e.v[13], e.v[12:9], e.v[8:5], e.v[4], e.v[3], e.v[2:0]);
      end
    end
  end

  initial begin
    AR = 1'b0; SERVE = 1'b0; BTN_L = 1'b0; BTN_R = 1'b0;

    // Reset values, then IDLE for exactly one cycle after release.
    go(1);
    expect_at(1, "reset", 0, 1, 0, 0, 0, 0, 0);
    AR = 1'b1;
    expect_at(2, "idle_exit", 0, 1, 0, 0, 0, 0, 1);

    // Serve and free run to a left miss, then the point pause.
    go(2);
    checks++;
    if (STATE !== 3'd1) begin
      errors++;
      $display("FAIL direct_idle_exit cycle %0d: state=%0d expected 1", cyc, STATE);
    end
    SERVE = 1'b1;
    expect_at(3, "serve_move", 0, 1, 0, 0, 0, 0, 2);
    expect_at(4, "first_hold", 0, 1, 0, 0, 0, 0, 2);
    for (int k = 1; k <= 7; k++) expect_at(3 + 2 * k, "step_up", k, 1, 0, 0, 0, 0, 2);
    expect_at(19, "miss_left", 7, 0, 0, 1, 1, 0, 3);
    expect_at(21, "flash_t1", 7, 0, 0, 1, 0, 0, 3);
    expect_at(23, "flash_t2", 7, 0, 0, 1, 1, 0, 3);
    expect_at(25, "flash_t3", 7, 0, 0, 1, 0, 0, 3);
    expect_at(27, "pause_end", 7, 0, 0, 1, 0, 0, 1);
    go(3);
    SERVE = 1'b0;

    // Re-serve toward 0, right hit via latch, left hit on the tick cycle.
    go(27);
    SERVE = 1'b1;
    expect_at(28, "reserve", 7, 0, 0, 1, 0, 0, 2);
    for (int k = 1; k <= 7; k++) expect_at(28 + 2 * k, "step_dn", 7 - k, 0, 0, 1, 0, 0, 2);
    go(28);
    SERVE = 1'b0;
    go(42);
    BTN_R = 1'b1;
    expect_at(44, "hit_right", 1, 1, 0, 1, 0, 0, 2);
    for (int k = 1; k <= 6; k++) expect_at(44 + 2 * k, "step_up2", 1 + k, 1, 0, 1, 0, 0, 2);
    expect_at(58, "hit_left_on_tick", 6, 0, 0, 1, 0, 0, 2);
    go(43);
    BTN_R = 1'b0;
    go(57);
    BTN_L = 1'b1;
    go(58);
    BTN_L = 1'b0;
    for (int k = 1; k <= 6; k++) expect_at(58 + 2 * k, "step_dn2", 6 - k, 0, 0, 1, 0, 0, 2);
    expect_at(72, "miss_right", 0, 1, 1, 1, 1, 0, 3);
    expect_at(80, "pause_end2", 0, 1, 1, 1, 0, 0, 1);

    // Early left press at POS 5 held high: no hit, miss ends the game.
    go(80);
    SERVE = 1'b1;
    expect_at(81, "serve3", 0, 1, 1, 1, 0, 0, 2);
    expect_at(91, "at5", 5, 1, 1, 1, 0, 0, 2);
    expect_at(95, "at7", 7, 1, 1, 1, 0, 0, 2);
    expect_at(97, "miss_after_early", 7, 0, 1, 2, 1, 0, 3);
    expect_at(105, "game_over", 7, 0, 1, 2, 0, 1, 4);
    expect_at(106, "over_hold", 7, 0, 1, 2, 0, 1, 4);
    go(81);
    SERVE = 1'b0;
    go(91);
    BTN_L = 1'b1;
    go(97);
    BTN_L = 1'b0;

    // Serve from GAME_OVER clears the game.
    go(106);
    checks++;
    if (STATE !== 3'd4 || OVER !== 1'b1) begin
      errors++;
      $display("FAIL direct_game_over cycle %0d: state=%0d over=%0d expected 4/1", cyc, STATE, OVER);
    end
    SERVE = 1'b1;
    expect_at(107, "new_game", 0, 1, 0, 0, 0, 0, 1);
    go(107);
    SERVE = 1'b0;

    // SERVE held through a rally: no re-serve after the point.
    go(108);
    SERVE = 1'b1;
    expect_at(109, "serve4", 0, 1, 0, 0, 0, 0, 2);
    expect_at(115, "mid4", 3, 1, 0, 0, 0, 0, 2);
    expect_at(125, "miss4", 7, 0, 0, 1, 1, 0, 3);
    expect_at(133, "wait4", 7, 0, 0, 1, 0, 0, 1);
    expect_at(135, "held_serve_ignored", 7, 0, 0, 1, 0, 0, 1);
    go(135);
    SERVE = 1'b0;
    go(136);
    SERVE = 1'b1;
    expect_at(137, "serve5", 7, 0, 0, 1, 0, 0, 2);
    expect_at(143, "pos4", 4, 0, 0, 1, 0, 0, 2);

    // Asynchronous reset mid-MOVE with buttons and SERVE held through it.
    expect_at(144, "async_reset", 0, 1, 0, 0, 0, 0, 0);
    expect_at(145, "reset_hold", 0, 1, 0, 0, 0, 0, 0);
    expect_at(146, "idle_exit2", 0, 1, 0, 0, 0, 0, 1);
    expect_at(148, "held_through_reset", 0, 1, 0, 0, 0, 0, 1);
    go(144);
    BTN_L = 1'b1;
    BTN_R = 1'b1;
    AR    = 1'b0;
    go(145);
    AR = 1'b1;
    go(148);
    SERVE = 1'b0;
    go(149);
    SERVE = 1'b1;
    expect_at(150, "serve6", 0, 1, 0, 0, 0, 0, 2);
    expect_at(152, "step6", 1, 1, 0, 0, 0, 0, 2);
    expect_at(164, "at7_held", 7, 1, 0, 0, 0, 0, 2);
    expect_at(166, "held_btn_no_hit", 7, 0, 0, 1, 1, 0, 3);

    go(170);
    SERVE = 1'b0; BTN_L = 1'b0; BTN_R = 1'b0;
    go(172);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s never checked: due cycle %0d, now %0d", e.nm, e.at, cyc);
    end
    if (checks < 12) begin
      errors++;
      $display("FAIL too few checks executed: %0d", checks);
    end
    if (errors == 0) $display("PASS");
    else             $display("FAIL");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pong_ctrl.md
# pong_ctrl

Game controller for the one-row ball display on the 8-digit seven-segment board. It owns the ball position, direction and step timing, and turns the two paddle buttons into hit/miss decisions. It keeps both players' scores and sequences serve, rally, point pause and game over. POS feeds the ball display decoder, FLASH blanks it, and SCORE_L/SCORE_R feed the digit decoders.

## Interface
- DIV, 24: step period is DIV+1 clock cycles (minimum 1).
- PAUSE, 8: number of step ticks spent in POINT.
- WIN_SCORE, 9: score that ends the game (1..15).

Ports:
- CLK  in  1  system clock (hz100).
- AR  in  1  asynchronous reset, active-low.
- SERVE  in  1  serve button, synchronous level.
- BTN_L  in  1  left paddle (position 7), synchronous level.
- BTN_R  in  1  right paddle (position 0), synchronous level.
- POS  out  3  ball position, 0..7.
- DIR  out  1  1 = moving toward 7, 0 = toward 0.
- SCORE_L  out  4  left player score.
- SCORE_R  out  4  right player score.
- FLASH  out  1  1 = display should blank the ball.
- OVER  out  1  high in GAME_OVER.
- STATE  out  3  IDLE=0, SERVE_WAIT=1, MOVE=2, POINT=3, GAME_OVER=4.

## Operation
Reset (AR=0) forces:
- STATE=IDLE, POS=0, DIR=1.
- Scores 0, FLASH=0, OVER=0.
- Step counter 0, hit latches 0.
- Edge-detect history registers set to 1, so a button held through reset produces no edge.

Edge detection and step tick:
- Rising edge of a button = level & ~previous level, with previous level registered each cycle.
- Step counter runs only in MOVE and POINT and counts 0..DIV.
- tick = (counter==DIV). The counter wraps to 0 on tick.
- The counter clears to 0 on every state entry.

IDLE: go to SERVE_WAIT unconditionally on the next cycle.

SERVE_WAIT:
- POS and DIR hold.
- SERVE edge -> MOVE.
- BTN edges are ignored.

MOVE, left hit window:
- The left hit latch sets on a BTN_L edge only while POS==7 and DIR==1.
- BTN_L edges at any other time are ignored.

MOVE, right hit window:
- The right hit latch sets on a BTN_R edge only while POS==0 and DIR==0.

MOVE, on tick:
- DIR==1, POS<7: POS+1.
- DIR==0, POS>0: POS-1.
- POS==7, DIR==1, left latch set: DIR<=0, POS<=6.
- POS==7, DIR==1, left latch clear: SCORE_R+1, go to POINT. POS stays 7 and DIR becomes 0, so the left player re-serves toward 0.
- POS==0, DIR==0: mirror image. Right latch set gives DIR<=1, POS<=1. Latch clear gives SCORE_L+1, POINT, POS stays 0, DIR becomes 1.
- Both hit latches clear on every tick.

POINT:
- FLASH toggles on each tick, starting at 1 on entry.
- After PAUSE ticks: FLASH<=0.
- If either score == WIN_SCORE, go to GAME_OVER; otherwise go to SERVE_WAIT.

GAME_OVER:
- OVER=1; POS, DIR and scores hold.
- SERVE edge: scores clear to 0, POS=0, DIR=1, go to SERVE_WAIT.

Arithmetic and precedence:
- Scores saturate at 15. They are unreachable beyond WIN_SCORE in normal play.
- A SERVE edge in MOVE or POINT is ignored.
- An edge arriving in the same cycle as a tick is latched before that tick's evaluation, so it counts as a hit.

## Timing
- All outputs are registered and update on the rising CLK edge.
- AR acts immediately and independently of CLK. Mid-rally reset returns every output to its reset value within the same cycle.
- SERVE edge at cycle n (SERVE high at n, low at n-1) -> STATE=MOVE at n+1. First POS change at n+1+DIV+1.
- Steady MOVE: POS changes exactly every DIV+1 cycles.
- Bounce costs one tick and does not dwell at the end: 6,7,6 on consecutive ticks.
- Miss: STATE=POINT and score increment occur in the same cycle as the miss tick's update.
- POINT lasts PAUSE*(DIV+1) cycles.
- IDLE lasts exactly one cycle after reset release.

## Test plan
- Reset release, SERVE pulse, DIV=1, no buttons -> POS 0→1…→7 every 2 cycles. At the tick at POS 7, SCORE_R=1, STATE=3, POS=7, DIR=0.
- Rally hit: BTN_L pulsed while POS==7, DIR==1 -> next tick gives POS=6, DIR=0 and no score change. BTN_L pulsed at POS==5 -> ignored, miss at 7.
- Button held through reset and SERVE held through the whole rally -> no hit registered and no extra serve. The only edges counted are fresh 0→1 transitions.
- Point pause, PAUSE=4, DIV=1 -> FLASH pattern 1,0,1,0 over 8 cycles, then STATE=1 with FLASH=0.
- Game end, WIN_SCORE=2: two left misses -> SCORE_R=2, OVER=1 after the pause. SERVE then gives scores 0, POS=0, DIR=1, STATE=1.
- AR pulsed low mid-MOVE at POS=4 with SCORE_L=3 -> all outputs take reset values asynchronously. After release, STATE=0 then 1.
